// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_ctrl_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: the pointed-to requester wins when it asks,
// otherwise the other one does.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (req[ptr]) begin
      grant[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      grant[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between two requesters; each accepted
// request runs IDLE -> ISSUE -> RESP with at most one transaction in flight.
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  op_q, op_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_REQ-1:0]    grant;

  rr_arbiter2 u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      op_q    <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    op_d      = op_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        // A non-zero grant is always a handshake since ready mirrors it.
        if (|grant) begin
          owner_d = grant[1];
          op_d    = req_write[grant[1]];
          addr_d  = grant[1] ? req_addr1 : req_addr0;
          wdata_d = grant[1] ? req_wdata1 : req_wdata0;
          ptr_d   = ~grant[1];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_wr_en = op_q;
        mem_rd_en = ~op_q;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_rdata          = op_q ? '0 : mem_rdata;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against
// a transaction-level reference and a behavioural memory with 0xFF reset contents.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [1:0] req_addr0, req_addr1, mem_addr;
  logic [7:0] req_wdata0, req_wdata1, rsp_rdata, mem_wdata, mem_rdata;
  logic       mem_wr_en, mem_rd_en, busy;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  mem_port_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0),
    .req_wdata1(req_wdata1), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: registers read data one edge after mem_rd_en.
  logic [7:0] smem [4];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) smem[i] <= 8'hFF;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_wr_en) smem[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= smem[mem_addr];
    end
  end

  // Transaction-level reference: accept cycle, then strobe at +1, response at +2.
  int         acc_cyc;
  bit         mptr, m_owner, m_wr;
  logic [1:0] m_addr;
  logic [7:0] m_wdata, m_rdata_exp;
  logic [7:0] ref_mem [4];
  logic [1:0] e_ready, e_rsp, e_addr;
  logic       e_wr, e_rd, e_busy;
  logic [7:0] e_wdata, e_rdata;

  task automatic model_reset();
    acc_cyc = -100; mptr = 1'b0; m_owner = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata_exp = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [1:0] a0,
                      input logic [1:0] a1, input logic [7:0] d0, input logic [7:0] d1);
    bit idle;
    @(negedge clk);
    req_valid = v; req_write = w; req_addr0 = a0; req_addr1 = a1;
    req_wdata0 = d0; req_wdata1 = d1;
    #1;
    idle = (cyc >= acc_cyc + 3);
    e_ready = '0;
    if (idle) begin
      if (v[mptr]) e_ready[mptr] = 1'b1;
      else if (v[!mptr]) e_ready[!mptr] = 1'b1;
    end
    e_wr = (cyc == acc_cyc + 1) && m_wr;
    e_rd = (cyc == acc_cyc + 1) && !m_wr;
    e_rsp = '0; e_rdata = '0;
    if (cyc == acc_cyc + 2) begin
      e_rsp[m_owner] = 1'b1;
      e_rdata = m_wr ? 8'h00 : m_rdata_exp;
    end
    e_busy = !idle; e_addr = m_addr; e_wdata = m_wdata;
    if (e_ready != 2'b00) begin
      m_owner = e_ready[1];
      m_wr    = w[m_owner];
      m_addr  = m_owner ? a1 : a0;
      m_wdata = m_owner ? d1 : d0;
      if (m_wr) ref_mem[m_addr] = m_wdata;
      m_rdata_exp = ref_mem[m_addr];
      mptr    = !m_owner;
      acc_cyc = cyc;
    end
  endtask

  task automatic idle_step();
    step(2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    req_valid = 2'b00;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 2'b00; req_write = 2'b00; req_addr0 = '0; req_addr1 = '0;
    req_wdata0 = '0; req_wdata1 = '0;
    assert_reset();
    @(posedge clk); #1;
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    nchk++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
    nchk++; if (rsp_rdata !== 8'h00) begin nfail++; $display("FAIL rst_rdata got=%h exp=00", rsp_rdata); end
    nchk++; if ({mem_wr_en, mem_rd_en} !== 2'b00) begin nfail++; $display("FAIL rst_strobes got=%b exp=00", {mem_wr_en, mem_rd_en}); end
    nchk++; if (mem_addr !== 2'b00 || mem_wdata !== 8'h00) begin nfail++; $display("FAIL rst_mem_cmd got=%h/%h exp=0/00", mem_addr, mem_wdata); end
    nchk++; if (req_ready !== 2'b00) begin nfail++; $display("FAIL rst_ready_none got=%b exp=00", req_ready); end
    req_valid = 2'b10; #1;
    nchk++; if (req_ready !== 2'b10) begin nfail++; $display("FAIL rst_ready_idle_rule got=%b exp=10", req_ready); end
    release_reset();
  endtask

  task automatic test_write_read();
    step(2'b01, 2'b01, 2'd1, 2'd0, 8'hA5, 8'h00);
    nchk++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL wr_ready got=%b exp=01", req_ready); end
    idle_step();
    nchk++; if ({mem_wr_en, mem_rd_en} !== 2'b10) begin nfail++; $display("FAIL wr_strobe got=%b exp=10", {mem_wr_en, mem_rd_en}); end
    nchk++; if (mem_addr !== 2'd1 || mem_wdata !== 8'hA5) begin nfail++; $display("FAIL wr_cmd got=%h/%h exp=1/a5", mem_addr, mem_wdata); end
    nchk++; if (req_ready !== 2'b00 || busy !== 1'b1) begin nfail++; $display("FAIL wr_issue_ready_busy got=%b/%b exp=00/1", req_ready, busy); end
    idle_step();
    nchk++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h00) begin nfail++; $display("FAIL wr_rsp got=%b/%h exp=01/00", rsp_valid, rsp_rdata); end
    nchk++; if ({mem_wr_en, mem_rd_en} !== 2'b00) begin nfail++; $display("FAIL wr_strobe_resp got=%b exp=00", {mem_wr_en, mem_rd_en}); end
    step(2'b10, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00);
    nchk++; if (req_ready !== 2'b10) begin nfail++; $display("FAIL rd_ready got=%b exp=10", req_ready); end
    idle_step();
    nchk++; if ({mem_wr_en, mem_rd_en} !== 2'b01 || mem_addr !== 2'd1) begin nfail++; $display("FAIL rd_strobe got=%b/%h exp=01/1", {mem_wr_en, mem_rd_en}, mem_addr); end
    idle_step();
    nchk++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'hA5) begin nfail++; $display("FAIL rd_rsp got=%b/%h exp=10/a5", rsp_valid, rsp_rdata); end
    idle_step();
    nchk++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin nfail++; $display("FAIL rd_after got=%b/%b exp=00/0", rsp_valid, busy); end
  endtask

  task automatic test_read_reset_value();
    assert_reset();
    release_reset();
    step(2'b01, 2'b00, 2'd3, 2'd0, 8'h00, 8'h00);
    nchk++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL ff_ready got=%b exp=01", req_ready); end
    idle_step();
    nchk++; if (mem_rd_en !== 1'b1 || mem_addr !== 2'd3) begin nfail++; $display("FAIL ff_strobe got=%b/%h exp=1/3", mem_rd_en, mem_addr); end
    idle_step();
    nchk++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'hFF) begin nfail++; $display("FAIL ff_rsp got=%b/%h exp=01/ff", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_alternation();
    int gnt_q[$];
    int gcyc_q[$];
    bit [31:0] r;
    assert_reset();
    release_reset();
    for (int i = 0; i < 18; i++) begin
      r = $urandom;
      step(2'b11, r[1:0], r[3:2], r[5:4], r[15:8], r[23:16]);
      if (req_ready != 2'b00) begin
        gnt_q.push_back(req_ready[1] ? 1 : 0);
        gcyc_q.push_back(cyc);
      end
      nchk++; if (rsp_valid !== e_rsp) begin nfail++; $display("FAIL alt_rsp cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp); end
    end
    nchk++; if (gnt_q.size() != 6) begin nfail++; $display("FAIL alt_count got=%0d exp=6", gnt_q.size()); end
    for (int i = 0; i < gnt_q.size(); i++) begin
      nchk++; if (gnt_q[i] != i % 2) begin nfail++; $display("FAIL alt_order idx=%0d got=%0d exp=%0d", i, gnt_q[i], i % 2); end
      if (i > 0) begin
        nchk++; if (gcyc_q[i] - gcyc_q[i-1] != 3) begin nfail++; $display("FAIL alt_spacing idx=%0d got=%0d exp=3", i, gcyc_q[i] - gcyc_q[i-1]); end
      end
    end
  endtask

  task automatic test_reset_in_issue();
    idle_step(); idle_step(); idle_step();
    step(2'b01, 2'b01, 2'd2, 2'd0, 8'h3C, 8'h00);
    idle_step();
    nchk++; if (mem_wr_en !== 1'b1) begin nfail++; $display("FAIL rii_pre_strobe got=%b exp=1", mem_wr_en); end
    assert_reset();
    nchk++; if ({mem_wr_en, mem_rd_en} !== 2'b00) begin nfail++; $display("FAIL rii_strobes got=%b exp=00", {mem_wr_en, mem_rd_en}); end
    nchk++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin nfail++; $display("FAIL rii_busy_rsp got=%b/%b exp=0/00", busy, rsp_valid); end
    release_reset();
    step(2'b11, 2'b00, 2'd0, 2'd1, 8'h00, 8'h00);
    nchk++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL rii_next_grant got=%b exp=01", req_ready); end
    nchk++; if (rsp_valid !== 2'b00) begin nfail++; $display("FAIL rii_no_rsp got=%b exp=00", rsp_valid); end
    idle_step();
    idle_step();
    nchk++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'hFF) begin nfail++; $display("FAIL rii_rsp got=%b/%h exp=01/ff", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_drop_while_busy();
    idle_step();
    step(2'b01, 2'b00, 2'd2, 2'd1, 8'h00, 8'h00);
    nchk++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL drop_ready0 got=%b exp=01", req_ready); end
    for (int i = 0; i < 2; i++) begin
      step(2'b10, 2'b00, 2'd2, 2'd1, 8'h00, 8'h00);
      nchk++; if (req_ready !== 2'b00) begin nfail++; $display("FAIL drop_busy_ready i=%0d got=%b exp=00", i, req_ready); end
    end
    nchk++; if (rsp_valid !== 2'b01) begin nfail++; $display("FAIL drop_rsp0 got=%b exp=01", rsp_valid); end
    for (int i = 0; i < 4; i++) begin
      idle_step();
      nchk++; if (rsp_valid[1] !== 1'b0 || busy !== 1'b0 || {mem_wr_en, mem_rd_en} !== 2'b00) begin
        nfail++; $display("FAIL drop_no_req1 i=%0d got=%b/%b/%b exp=0/0/00", i, rsp_valid[1], busy, {mem_wr_en, mem_rd_en});
      end
    end
  endtask

  task automatic test_random();
    bit [31:0] r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      step(r[1:0], r[3:2], r[5:4], r[7:6], r[15:8], r[23:16]);
      nchk++; if (req_ready !== e_ready) begin nfail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
      nchk++; if (mem_wr_en !== e_wr) begin nfail++; $display("FAIL rnd_wr_en cyc=%0d got=%b exp=%b", cyc, mem_wr_en, e_wr); end
      nchk++; if (mem_rd_en !== e_rd) begin nfail++; $display("FAIL rnd_rd_en cyc=%0d got=%b exp=%b", cyc, mem_rd_en, e_rd); end
      nchk++; if (mem_addr !== e_addr) begin nfail++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, e_addr); end
      nchk++; if (mem_wdata !== e_wdata) begin nfail++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, e_wdata); end
      nchk++; if (rsp_valid !== e_rsp) begin nfail++; $display("FAIL rnd_rsp cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp); end
      nchk++; if (rsp_rdata !== e_rdata) begin nfail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rsp_rdata, e_rdata); end
      nchk++; if (busy !== e_busy) begin nfail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_read_reset_value();
    test_alternation();
    test_reset_in_issue();
    test_drop_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 2, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 SHALL have port req_write  input  2  per-requester op: 1 write, 0 read.
REQ-007 SHALL have ports req_addr0, req_addr1  input  ADDR_WIDTH each  requester address.
REQ-008 SHALL have ports req_wdata0, req_wdata1  input  DATA_WIDTH each  requester write data.
REQ-009 SHALL have port req_ready  output  2  per-requester acceptance; request accepted when valid and ready both high on a clk edge.
REQ-010 SHALL have port rsp_valid  output  2  one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, meaningful only with rsp_valid for a read.
REQ-012 SHALL have ports mem_addr (ADDR_WIDTH), mem_wr_en (1), mem_rd_en (1), mem_wdata (DATA_WIDTH)  output  memory command.
REQ-013 SHALL have port mem_rdata  input  DATA_WIDTH  memory read data, registered by memory one edge after mem_rd_en sampled.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; every transaction occupies exactly 3 cycles, one outstanding at most.
REQ-016 In IDLE, req_ready SHALL be one-hot to the arbitration winner among asserted req_valid bits, combinationally; zero when no req_valid; req_ready SHALL be 0 in ISSUE and RESP.
REQ-017 Arbitration SHALL be round-robin: pointer names preferred requester; on each acceptance pointer moves to the non-granted requester.
REQ-018 On acceptance, op, address, write data and owner index SHALL be captured into registers; IDLE -> ISSUE.
REQ-019 In ISSUE, exactly one of mem_wr_en/mem_rd_en SHALL be high for one cycle with mem_addr/mem_wdata from captured registers; ISSUE -> RESP.
REQ-020 mem_wr_en and mem_rd_en SHALL never be high simultaneously and SHALL be 0 outside ISSUE.
REQ-021 In RESP, rsp_valid[owner] SHALL be high for that cycle only; for reads rsp_rdata SHALL equal mem_rdata; for writes rsp_rdata SHALL be 0; RESP -> IDLE.
REQ-022 Accept-to-rsp_valid latency SHALL be 2 cycles; peak throughput one transaction per 3 cycles.
REQ-023 A requester deasserting req_valid before acceptance SHALL cause no transaction; a single continuously-valid requester SHALL be granted every transaction.
REQ-024 With both req_valid high continuously, grants SHALL alternate 0,1,0,1...; neither requester waits more than one transaction.
REQ-025 mem_addr and mem_wdata SHALL hold captured values outside ISSUE (no glitch requirement on memory side).

Reset
REQ-026 Reset SHALL asynchronously force state IDLE, pointer to requester 0, all captured registers 0.
REQ-027 During/after reset: req_ready follows IDLE rule, rsp_valid=0, rsp_rdata=0, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-028 Reset mid-transaction SHALL abort it with no rsp_valid pulse and no memory strobe after reset asserts.

Structure
REQ-029 Shared package mem_ctrl_pkg SHALL hold the FSM state enum (IDLE, ISSUE, RESP) and requester-count constant 2.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs req[1:0], pointer; output one-hot grant).

Verification
REQ-031 Req0 write addr 1 data 8'hA5 -> mem_wr_en one cycle, addr 1, wdata A5; rsp_valid=2'b01 two cycles after acceptance.
REQ-032 Then req1 read addr 1 -> mem_rd_en one cycle; rsp_valid=2'b10 with rsp_rdata=8'hA5.
REQ-033 Both requesters valid for 6 transactions after reset -> grant order 0,1,0,1,0,1; one transaction per 3 cycles.
REQ-034 Read addr 3 after memory reset (contents 8'hFF) -> rsp_rdata=8'hFF.
REQ-035 Reset asserted in ISSUE cycle -> strobes drop immediately, no rsp_valid, busy=0, next grant to requester 0.
REQ-036 Req1 valid two cycles then dropped while busy serving req0 -> no req1 transaction, no rsp_valid[1].
